sand_step_engine: RTL

Per-frame physics engine for the falling-sand grid. On each `start_i` it scans the cell grid bottom-up and moves every sand grain one step down, or diagonally down when blocked. It reads cells through the two combinational read ports of `register_file_dual_port_read` and writes results through that block's single write port. It sits directly upstream of the register file as that block's only writer; the frame scheduler pulses `start_i` once per frame.

---
 rtl/sand_step_engine.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sand_step_engine.sv
// Falling-sand frame engine: scans the grid bottom-up once per start pulse and
// moves each grain one cell down, or diagonally down when the cell below is taken.
module sand_step_engine #(
   parameter int                    WIDTH      = 16,
   parameter int                    HEIGHT     = 16,
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] SAND       = DATA_WIDTH'(1)
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [ADDR_WIDTH-1:0] rd_address_1_o,
   output logic [ADDR_WIDTH-1:0] rd_address_2_o,
   input  logic [DATA_WIDTH-1:0] rd_data_1_i,
   input  logic [DATA_WIDTH-1:0] rd_data_2_i,
   output logic                  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_address_o,
   output logic [DATA_WIDTH-1:0] wr_data_o
);

   localparam int             XW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int             YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [XW-1:0]  X_MAX   = XW'(WIDTH - 1);
   localparam logic [YW-1:0]  Y_START = YW'(HEIGHT - 2);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SCAN, ST_DIAG_A, ST_DIAG_B, ST_WR_DST, ST_WR_SRC, ST_NEXT, ST_DONE
   } state_e;

   function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [XW-1:0] cx,
                                                       input logic [YW-1:0] cy);
      return ADDR_WIDTH'(int'(cy) * WIDTH + int'(cx));
   endfunction

   state_e                  state_q, state_d;
   logic [XW-1:0]           x_q, x_d;
   logic [YW-1:0]           y_q, y_d;
   logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
   logic                    prefer_left_q, prefer_left_d;

   logic [YW-1:0]           y_below;
   logic                    left_ok, right_ok, first_ok, second_ok;
   logic [ADDR_WIDTH-1:0]   addr_src, addr_below, addr_left, addr_right;
   logic [ADDR_WIDTH-1:0]   first_addr, second_addr;

   // Edge columns have only one diagonal; the missing one counts as blocked.
   assign y_below     = y_q + 1'b1;
   assign left_ok     = (x_q != '0);
   assign right_ok    = (x_q != X_MAX);
   assign addr_src    = cell_addr(x_q, y_q);
   assign addr_below  = cell_addr(x_q, y_below);
   assign addr_left   = cell_addr(x_q - 1'b1, y_below);
   assign addr_right  = cell_addr(x_q + 1'b1, y_below);
   assign first_ok    = prefer_left_q ? left_ok    : right_ok;
   assign second_ok   = prefer_left_q ? right_ok   : left_ok;
   assign first_addr  = prefer_left_q ? addr_left  : addr_right;
   assign second_addr = prefer_left_q ? addr_right : addr_left;

   // NOTE: state lives in always_ff with non-blocking assignments only, so every
   // register samples the same pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q       <= ST_IDLE;
         x_q           <= '0;
         y_q           <= '0;
         dst_q         <= '0;
         prefer_left_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         dst_q         <= dst_d;
         prefer_left_q <= prefer_left_d;
      end
   end

   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      dst_d         = dst_q;
      prefer_left_d = prefer_left_q;
      unique case (state_q)
         ST_IDLE: if (start_i) begin
            x_d     = '0;
            y_d     = Y_START;
            state_d = ST_SCAN;
         end
         ST_SCAN: begin
            if (rd_data_1_i != SAND) begin
               state_d = ST_NEXT;
            end else if (rd_data_2_i == '0) begin
               dst_d   = addr_below;
               state_d = ST_WR_DST;
            end else begin
               state_d = ST_DIAG_A;
            end
         end
         ST_DIAG_A: begin
            if (first_ok && rd_data_2_i == '0) begin
               dst_d   = first_addr;
               state_d = ST_WR_DST;
            end else begin
               state_d = ST_DIAG_B;
            end
         end
         ST_DIAG_B: begin
            if (second_ok && rd_data_2_i == '0) begin
               dst_d   = second_addr;
               state_d = ST_WR_DST;
            end else begin
               state_d = ST_NEXT;
            end
         end
         ST_WR_DST: state_d = ST_WR_SRC;
         ST_WR_SRC: state_d = ST_NEXT;
         ST_NEXT: begin
            if (x_q != X_MAX) begin
               x_d     = x_q + 1'b1;
               state_d = ST_SCAN;
            end else if (y_q != '0) begin
               x_d     = '0;
               y_d     = y_q - 1'b1;
               state_d = ST_SCAN;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            prefer_left_d = ~prefer_left_q;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o         = (state_q != ST_IDLE) && (state_q != ST_DONE);
      done_o         = (state_q == ST_DONE);
      rd_address_1_o = '0;
      rd_address_2_o = '0;
      wr_en_o        = 1'b0;
      wr_address_o   = '0;
      wr_data_o      = '0;
      unique case (state_q)
         ST_SCAN: begin
            rd_address_1_o = addr_src;
            rd_address_2_o = addr_below;
         end
         ST_DIAG_A: begin
            rd_address_1_o = addr_src;
            rd_address_2_o = first_ok ? first_addr : addr_below;
         end
         ST_DIAG_B: begin
            rd_address_1_o = addr_src;
            rd_address_2_o = second_ok ? second_addr : addr_below;
         end
         ST_WR_DST: begin
            wr_en_o      = 1'b1;
            wr_address_o = dst_q;
            wr_data_o    = SAND;
         end
         ST_WR_SRC: begin
            wr_en_o      = 1'b1;
            wr_address_o = addr_src;
         end
         default: ;
      endcase
   end

endmodule
